signal_gen: RTL and testbench
=============================

SIGNAL_GEN -- requirements
Module: signal_gen

Interface
REQ-001 SHALL have port sys_clk, input, 1, single system clock; all logic on its rising edge.
REQ-002 SHALL have port sys_rst, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port control_clk, input, 1, divided rate clock from the upstream clock divider, treated as data and never used as a clock.
REQ-004 SHALL have port wave_sel, input, 2, waveform select: 00 sawtooth, 01 square, 10 triangle, 11 noise/zero (see REQ-024).
REQ-005 SHALL have port phase_step, input, 16, unsigned phase increment applied per tick.
REQ-006 SHALL have port sample_ready, input, 1, downstream FIR accepts the sample.
REQ-007 SHALL have port overrun_clr, input, 1, clears the overrun flag.
REQ-008 SHALL have port sample_data, output, 16, two's-complement sample.
REQ-009 SHALL have port sample_valid, output, 1, sample_data holds an unaccepted sample.
REQ-010 SHALL have port overrun, output, 1, sticky flag: a tick arrived while a sample was pending.

Function
REQ-011 SHALL synchronise control_clk through 2 flops, then rising-edge detect with a 3rd flop to form a 1-cycle tick.
- Timing: sample_valid rises at the 3rd sys_clk edge after the first edge that samples control_clk high.
REQ-012 SHALL keep a 16-bit phase_acc.
- On each tick: phase_acc <= phase_acc + phase_step, modulo 2^16, wrap silently.
- The sample for that tick SHALL be computed from phase_acc before the increment.
REQ-013 SHALL sample wave_sel and phase_step only on the tick cycle.
REQ-014 Sawtooth SHALL equal phase_acc with bit 15 inverted.
REQ-015 Square SHALL be 16'h7FFF when phase_acc[15]=0, else 16'h8001.
REQ-016 Triangle SHALL be {t,1'b0} with bit 15 inverted.
- t = phase_acc[14:0] when phase_acc[15]=0, else ~phase_acc[14:0].
REQ-017 Handshake: a transfer SHALL occur on a cycle with sample_valid=1 and sample_ready=1.
- While sample_valid=1 and no transfer occurs, sample_data SHALL hold stable.
REQ-018 Tick with sample_valid=0, or with a transfer in the same cycle: SHALL load the new sample and set sample_valid=1; overrun unchanged.
REQ-019 Tick with sample_valid=1 and sample_ready=0: SHALL keep the old sample, set overrun=1, and still advance phase_acc (and LFSR).
REQ-020 Transfer without a tick: SHALL clear sample_valid at the next edge.
REQ-021 overrun SHALL clear on overrun_clr=1.
- Simultaneous set and clear: set wins.

Reset
REQ-022 On sys_rst=0 the block SHALL immediately set the following, independent of sys_clk:
- sample_data=0, sample_valid=0, overrun=0
- phase_acc=0, all synchroniser flops=0, LFSR=16'hACE1
REQ-023 Reset asserted mid-operation SHALL drop any pending sample.
- After release, the first tick SHALL require a fresh low-to-high transition of control_clk. A control_clk already high at release SHALL NOT tick.

Configuration
REQ-024 Macro SIGNAL_GEN_NOISE_EN controls wave_sel=11.
- Defined: wave_sel=11 SHALL output the 16-bit Fibonacci LFSR state before advance.
- LFSR next state = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}, advanced on every tick regardless of wave_sel.
- Undefined: wave_sel=11 SHALL output 16'h0000, and no LFSR logic SHALL be present.

Verification
REQ-025 Sawtooth: wave_sel=00, phase_step=16'h1000, sample_ready=1, 17 control_clk rising edges -> samples 8000, 9000, ..., 7000, then 8000 (wrap); overrun=0.
REQ-026 Square and triangle, phase_step=16'h4000:
- Square -> 7FFF, 7FFF, 8001, 8001.
- Triangle -> 8000, 0000, 7FFE, FFFE.
REQ-027 Backpressure: sample_ready=0, 2 ticks -> sample_data stays at the first sample and overrun=1.
- Then sample_ready=1 -> sample_valid drops next cycle.
- The next tick's sample reflects 2 phase advances.
- overrun_clr pulse -> overrun=0; overrun_clr on the same cycle as an overrun-causing tick -> overrun=1.
REQ-028 Latency and sync: control_clk raised between sys_clk edges -> sample_valid high exactly at the 3rd edge after the first edge sampling it high.
- control_clk held high for 1000 cycles -> exactly one sample.
REQ-029 Reset and noise:
- sys_rst low mid-stream -> all outputs 0 immediately, with no tick after release while control_clk stays high.
- With SIGNAL_GEN_NOISE_EN, wave_sel=11 -> first sample ACE1, second 59C3.
- Without SIGNAL_GEN_NOISE_EN, wave_sel=11 -> 0000.

Source files
------------

// File: rtl/signal_gen_if.sv
// -----------------------------------------------------------------------------
// signal_gen_if -- sample bus between the waveform generator and the FIR.
//
// Signals
//   wave_sel     [1:0]  waveform select (00 saw, 01 square, 10 triangle, 11 noise/zero)
//   phase_step   [15:0] unsigned phase increment per tick
//   sample_ready        downstream accepts the presented sample
//   overrun_clr         clears the sticky overrun flag
//   sample_data  [15:0] two's-complement sample
//   sample_valid        sample_data holds a sample not yet accepted
//   overrun             sticky: a tick arrived while a sample was still pending
//
// Handshake: a transfer happens on every sys_clk rising edge where
// sample_valid=1 and sample_ready=1. While sample_valid=1 and no transfer has
// happened, sample_data is held stable. sample_ready may be asserted at any
// time and does not depend on sample_valid.
//
// Modports
//   master : the side that selects the waveform and consumes samples
//   slave  : the generator itself
// -----------------------------------------------------------------------------
interface signal_gen_if;
  logic [1:0]  wave_sel;
  logic [15:0] phase_step;
  logic        sample_ready;
  logic        overrun_clr;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        overrun;

  modport master (
    output wave_sel, phase_step, sample_ready, overrun_clr,
    input  sample_data, sample_valid, overrun
  );

  modport slave (
    input  wave_sel, phase_step, sample_ready, overrun_clr,
    output sample_data, sample_valid, overrun
  );
endinterface

// File: rtl/signal_gen.sv
// -----------------------------------------------------------------------------
// signal_gen -- phase-accumulator waveform generator feeding a FIR.
//
// A divided "control_clk" (treated purely as data) is synchronised into the
// sys_clk domain and turned into a one-cycle tick. Each tick produces one
// sample from the current phase accumulator and then advances the phase by
// phase_step. Samples are offered on a valid/ready port; a tick that finds
// the previous sample still pending keeps that sample and raises overrun.
//
// Ports
//   sys_clk      system clock, everything on its rising edge
//   sys_rst      asynchronous active-low reset
//   control_clk  divided rate clock, sampled as data
//   bus          signal_gen_if.slave (wave_sel, phase_step, sample_ready,
//                overrun_clr in; sample_data, sample_valid, overrun out)
//
// Build option
//   SIGNAL_GEN_NOISE_EN  when defined, wave_sel=11 outputs a 16-bit Fibonacci
//                        LFSR (seed ACE1, advanced every tick); when undefined
//                        wave_sel=11 outputs zero and no LFSR exists.
// -----------------------------------------------------------------------------
module signal_gen (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          control_clk,
  signal_gen_if.slave   bus
);

  // synchroniser / edge detector state
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  // live_q: sync1_q holds a real post-reset sample of control_clk
  logic live_q, live_d;
  // arm_q: a low level has been seen since reset, so the next rise is fresh
  logic arm_q, arm_d;
  logic tick_q, tick_d;

  // datapath state
  logic [15:0] phase_acc_q, phase_acc_d;
  logic [15:0] sample_data_q, sample_data_d;
  logic        sample_valid_q, sample_valid_d;
  logic        overrun_q, overrun_d;

  logic [14:0] tri_t;
  logic [15:0] wave;
  logic        xfer;
  logic        overrun_set;

`ifdef SIGNAL_GEN_NOISE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;
`endif

  // ---------------------------------------------------------------------------
  // control_clk synchroniser and tick generation
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d = control_clk;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    live_d  = 1'b1;
    // A control_clk already high when reset releases must not count as a rise,
    // so ticks are only allowed once a genuine low has been sampled.
    arm_d   = arm_q | (live_q & ~sync1_q);
    // Registered pulse: the sample lands on the third edge after control_clk
    // is first sampled high.
    tick_d  = arm_q & sync2_q & ~sync3_q;
  end

  // ---------------------------------------------------------------------------
  // waveform select, computed from the phase before this tick's advance
  // ---------------------------------------------------------------------------
  always_comb begin
    tri_t = phase_acc_q[15] ? ~phase_acc_q[14:0] : phase_acc_q[14:0];
    wave  = 16'h0000;
    case (bus.wave_sel)
      2'b00:   wave = phase_acc_q ^ 16'h8000;
      2'b01:   wave = phase_acc_q[15] ? 16'h8001 : 16'h7FFF;
      2'b10:   wave = {tri_t, 1'b0} ^ 16'h8000;
      default: begin
`ifdef SIGNAL_GEN_NOISE_EN
        wave = lfsr_q;
`else
        wave = 16'h0000;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // phase accumulator, sample register and overrun flag
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_acc_d    = phase_acc_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = sample_valid_q;
    overrun_set    = 1'b0;
    xfer           = sample_valid_q & bus.sample_ready;

    if (tick_q) begin
      // phase always advances, even when the sample is dropped
      phase_acc_d = phase_acc_q + bus.phase_step;
      if (!sample_valid_q || xfer) begin
        sample_data_d  = wave;
        sample_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (xfer) begin
      sample_valid_d = 1'b0;
    end

    // set has priority over clear
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

`ifdef SIGNAL_GEN_NOISE_EN
  always_comb begin
    lfsr_d = lfsr_q;
    if (tick_q) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync3_q        <= 1'b0;
      live_q         <= 1'b0;
      arm_q          <= 1'b0;
      tick_q         <= 1'b0;
      phase_acc_q    <= 16'h0000;
      sample_data_q  <= 16'h0000;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      sync3_q        <= sync3_d;
      live_q         <= live_d;
      arm_q          <= arm_d;
      tick_q         <= tick_d;
      phase_acc_q    <= phase_acc_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.sample_data  = sample_data_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_signal_gen.sv
// -----------------------------------------------------------------------------
// tb_signal_gen -- directed bench for signal_gen.
// Expected samples are hand-computed and queued in exp_q; each tick pops one.
// -----------------------------------------------------------------------------
module tb_signal_gen;

  logic sys_clk;
  logic sys_rst;
  logic control_clk;

  signal_gen_if sif ();

  signal_gen dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .control_clk (control_clk),
    .bus         (sif)
  );

  // ---------------------------------------------------------------------------
  // clock and watchdog
  // ---------------------------------------------------------------------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  // advance n rising edges, ending 1ns after the last one
  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    control_clk = 1'b0;
    sys_rst     = 1'b0;
    cycles(3);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    cycles(4);
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk);
      #1;
      if (sif.sample_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_timeout"}, 16'h0000, 16'h0001);
  endtask

  // one control_clk pulse; the resulting sample is compared with exp_q's head
  task automatic tick_check(input string tag);
    bit          ok;
    logic [15:0] e;
    @(negedge sys_clk);
    control_clk = 1'b1;
    wait_valid(tag, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    if (ok) check(tag, sif.sample_data, e);
    @(negedge sys_clk);
    control_clk = 1'b0;
    cycles(4);
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  logic [15:0] saw_v [17] = '{16'h8000, 16'h9000, 16'hA000, 16'hB000,
                              16'hC000, 16'hD000, 16'hE000, 16'hF000,
                              16'h0000, 16'h1000, 16'h2000, 16'h3000,
                              16'h4000, 16'h5000, 16'h6000, 16'h7000,
                              16'h8000};
  logic [15:0] sq_v  [4]  = '{16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001};
  logic [15:0] tri_v [4]  = '{16'h8000, 16'h0000, 16'h7FFE, 16'hFFFE};

  initial begin
    int hi_cnt;

    sys_rst          = 1'b1;
    control_clk      = 1'b0;
    sif.wave_sel     = 2'b00;
    sif.phase_step   = 16'h1000;
    sif.sample_ready = 1'b1;
    sif.overrun_clr  = 1'b0;

    // reset values, checked before any clock edge
    #2;
    sys_rst = 1'b0;
    #1;
    check("rst_data",    sif.sample_data,           16'h0000);
    check("rst_valid",   16'(sif.sample_valid),     16'h0000);
    check("rst_overrun", 16'(sif.overrun),          16'h0000);
    cycles(2);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    cycles(4);

    // sawtooth, 17 ticks with wrap
    foreach (saw_v[i]) exp_q.push_back(saw_v[i]);
    for (int i = 0; i < 17; i++) tick_check($sformatf("saw%0d", i));
    check("saw_overrun", 16'(sif.overrun), 16'h0000);

    // square
    do_reset();
    sif.wave_sel   = 2'b01;
    sif.phase_step = 16'h4000;
    foreach (sq_v[i]) exp_q.push_back(sq_v[i]);
    for (int i = 0; i < 4; i++) tick_check($sformatf("sq%0d", i));

    // triangle
    do_reset();
    sif.wave_sel = 2'b10;
    foreach (tri_v[i]) exp_q.push_back(tri_v[i]);
    for (int i = 0; i < 4; i++) tick_check($sformatf("tri%0d", i));

    // latency: control_clk rises mid-cycle, E0 is the first edge seeing it
    do_reset();
    sif.wave_sel   = 2'b00;
    sif.phase_step = 16'h1000;
    @(negedge sys_clk);
    control_clk = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge sys_clk);
      #1;
      check($sformatf("lat_e%0d", k), 16'(sif.sample_valid), 16'h0000);
    end
    @(posedge sys_clk);
    #1;
    check("lat_e3",      16'(sif.sample_valid), 16'h0001);
    check("lat_e3_data", sif.sample_data,       16'h8000);
    // held high: exactly one sample in total
    hi_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (sif.sample_valid === 1'b1) hi_cnt++;
      cycles(1);
    end
    check("hold_one", 16'(hi_cnt), 16'h0001);
    @(negedge sys_clk);
    control_clk = 1'b0;
    cycles(4);

    // backpressure
    do_reset();
    sif.sample_ready = 1'b0;
    exp_q.push_back(16'h8000);
    tick_check("bp_first");
    @(negedge sys_clk);
    control_clk = 1'b1;
    cycles(6);
    check("bp_hold_data",  sif.sample_data,       16'h8000);
    check("bp_hold_valid", 16'(sif.sample_valid), 16'h0001);
    check("bp_overrun",    16'(sif.overrun),      16'h0001);
    @(negedge sys_clk);
    control_clk = 1'b0;
    cycles(4);
    sif.sample_ready = 1'b1;
    cycles(1);
    check("bp_drop_valid", 16'(sif.sample_valid), 16'h0000);
    exp_q.push_back(16'hA000);   // two phase advances were taken
    tick_check("bp_after");
    check("bp_overrun_sticky", 16'(sif.overrun), 16'h0001);
    sif.overrun_clr = 1'b1;
    cycles(1);
    sif.overrun_clr = 1'b0;
    check("ovr_clr", 16'(sif.overrun), 16'h0000);

    // clear coinciding with an overrun-causing tick
    sif.sample_ready = 1'b0;
    exp_q.push_back(16'hB000);
    tick_check("bp_pend");
    check("bp_pend_overrun", 16'(sif.overrun), 16'h0000);
    @(negedge sys_clk);
    control_clk = 1'b1;
    cycles(2);                  // 1ns after E1; tick is sampled at E3
    sif.overrun_clr = 1'b1;
    cycles(2);                  // 1ns after E3
    sif.overrun_clr = 1'b0;
    check("set_wins",      16'(sif.overrun), 16'h0001);
    check("set_wins_data", sif.sample_data,  16'hB000);
    @(negedge sys_clk);
    control_clk = 1'b0;
    cycles(4);

    // mid-stream reset with a pending sample and control_clk held high
    @(negedge sys_clk);
    control_clk = 1'b1;
    cycles(6);
    #2;
    sys_rst = 1'b0;
    #1;
    check("mid_rst_data",    sif.sample_data,       16'h0000);
    check("mid_rst_valid",   16'(sif.sample_valid), 16'h0000);
    check("mid_rst_overrun", 16'(sif.overrun),      16'h0000);
    cycles(2);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    sif.sample_ready = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (sif.sample_valid === 1'b1) hi_cnt++;
    end
    check("no_tick_after_rst", 16'(hi_cnt), 16'h0000);
    @(negedge sys_clk);
    control_clk = 1'b0;
    cycles(4);
    exp_q.push_back(16'h8000);  // phase restarted from zero
    tick_check("post_rst");

    // noise select
    do_reset();
    sif.wave_sel = 2'b11;
`ifdef SIGNAL_GEN_NOISE_EN
    exp_q.push_back(16'hACE1);
    exp_q.push_back(16'h59C3);
`else
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
`endif
    tick_check("noise0");
    tick_check("noise1");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
